branch_predictor: RTL and testbench

//   Fetch-side predictor paired with branch_control. In IF, looks up if_pc in a direct-mapped,

---
 rtl/branch_predictor_pkg.sv | 18 +
 rtl/branch_predictor_sat_counter2.sv | 22 ++
 rtl/branch_predictor.sv | 117 +++++++++++
 tb/tb_branch_predictor.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
// Holds the 2-bit counter encodings and the saturating statistics increment.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } bp_ctr_e;

    localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] stat_inc(input logic [31:0] value);
        return (value == STAT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating counter step used when training a table entry.
// Counts up on taken, down on not-taken, holding at both ends.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] ctr_in,
    input  logic       taken,
    output logic [1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (taken) begin
            if (ctr_in != BP_ST) begin
                ctr_out = ctr_in + 2'd1;
            end
        end else if (ctr_in != BP_SNT) begin
            ctr_out = ctr_in - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped, tagged 2-bit-counter branch predictor with target storage.
// Predicts in IF, trains and reports mispredicts in EX, and counts branches and mispredicts.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_pred_taken,
    input  logic [XLEN-1:0] upd_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            stat_clr,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    logic              valid_q [ENTRIES];
    logic [TAG_W-1:0]  tag_q   [ENTRIES];
    logic [1:0]        ctr_q   [ENTRIES];
    logic [XLEN-1:0]   tgt_q   [ENTRIES];

    logic [31:0]       branch_cnt;
    logic [31:0]       mispred_cnt;

    logic [IDX_BITS-1:0] if_idx;
    logic [TAG_W-1:0]    if_tag;
    logic                if_hit;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]    upd_tag;
    logic                upd_hit;
    logic [1:0]          upd_ctr_next;
    logic                upd_live;
    logic                unused_pc_bits;

    assign if_idx  = if_pc[IDX_BITS+1:2];
    assign if_tag  = if_pc[XLEN-1:IDX_BITS+2];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_BITS+2];
    assign unused_pc_bits = ^if_pc[1:0];

    // Lookup reads the registered table, so a same-cycle update is seen one cycle later.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? tgt_q[if_idx] : '0;

    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    sat_counter2 u_sat_counter2 (
        .ctr_in  (ctr_q[upd_idx]),
        .taken   (upd_taken),
        .ctr_out (upd_ctr_next)
    );

    // An update arriving while reset is held is dropped, including its flush request.
    assign upd_live   = upd_valid && rst_n;
    assign mispredict = upd_live &&
                        ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = !mispredict ? '0 :
                         upd_taken   ? upd_target : upd_pc + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= BP_WNT;
                tgt_q[i]   <= '0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                ctr_q[upd_idx] <= upd_ctr_next;
                if (upd_taken) begin
                    tgt_q[upd_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= upd_target;
                ctr_q[upd_idx]   <= BP_WT;
            end
        end
    end

    // Clearing wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (stat_clr) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (upd_valid) begin
            branch_cnt <= stat_inc(branch_cnt);
            if (mispredict) begin
                mispred_cnt <= stat_inc(mispred_cnt);
            end
        end
    end

    assign stat_branches = branch_cnt;
    assign stat_mispred  = mispred_cnt;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor with a table-of-entries reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        stat_clr;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;

    int vectorCount = 0;
    int missCount   = 0;
    bit checking    = 0;

    bit              mValid [64];
    int unsigned     mTag   [64];
    int              mStrength [64];
    logic [31:0]     mTarget [64];
    longint unsigned mBranches;
    longint unsigned mMispred;

    branch_predictor dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc),
        .stat_clr        (stat_clr),
        .stat_branches   (stat_branches),
        .stat_mispred    (stat_mispred)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned mIdx(input logic [31:0] pc);
        return (pc >> 2) % 64;
    endfunction

    function automatic bit mPredTaken(input logic [31:0] pc);
        int unsigned i;
        i = mIdx(pc);
        return mValid[i] && (mTag[i] == (pc >> 8)) && (mStrength[i] >= 2);
    endfunction

    function automatic logic [31:0] mPredTarget(input logic [31:0] pc);
        return mPredTaken(pc) ? mTarget[mIdx(pc)] : 32'h0;
    endfunction

    function automatic bit mMis();
        return rst_n && upd_valid &&
               ((upd_taken != upd_pred_taken) || (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    function automatic logic [31:0] mRedirect();
        if (!mMis()) return 32'h0;
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: trains a plain array of entries from the resolved outcome.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mValid[i] = 0;
                mTag[i] = 0;
                mStrength[i] = 1;
                mTarget[i] = 32'h0;
            end
            mBranches = 0;
            mMispred = 0;
        end else begin
            if (stat_clr) begin
                mBranches = 0;
                mMispred = 0;
            end else if (upd_valid) begin
                if (mBranches < 64'hFFFF_FFFF) mBranches++;
                if (mMis() && mMispred < 64'hFFFF_FFFF) mMispred++;
            end
            if (upd_valid) begin
                int unsigned i;
                i = mIdx(upd_pc);
                if (mValid[i] && mTag[i] == (upd_pc >> 8)) begin
                    if (upd_taken) begin
                        mStrength[i] = (mStrength[i] < 3) ? mStrength[i] + 1 : 3;
                        mTarget[i] = upd_target;
                    end else begin
                        mStrength[i] = (mStrength[i] > 0) ? mStrength[i] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    mValid[i] = 1;
                    mTag[i] = upd_pc >> 8;
                    mTarget[i] = upd_target;
                    mStrength[i] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("model pred_taken", {31'h0, pred_taken}, {31'h0, mPredTaken(if_pc)});
            checkOutput("model pred_target", pred_target, mPredTarget(if_pc));
            checkOutput("model mispredict", {31'h0, mispredict}, {31'h0, mMis()});
            checkOutput("model redirect_pc", redirect_pc, mRedirect());
            checkOutput("model stat_branches", stat_branches, mBranches[31:0]);
            checkOutput("model stat_mispred", stat_mispred, mMispred[31:0]);
        end
    end

    task automatic applyStimulus(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                                 input logic ut, input logic [31:0] utgt, input logic upt,
                                 input logic [31:0] uptgt, input logic clr);
        @(posedge clk);
        #1;
        if_pc = pc;
        upd_valid = uv;
        upd_pc = upc;
        upd_taken = ut;
        upd_target = utgt;
        upd_pred_taken = upt;
        upd_pred_target = uptgt;
        stat_clr = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic lookup(input logic [31:0] pc);
        applyStimulus(pc, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic checkPred(input string name, input logic expTaken, input logic [31:0] expTarget);
        checkOutput({name, " taken"}, {31'h0, pred_taken}, {31'h0, expTaken});
        checkOutput({name, " target"}, pred_target, expTarget);
    endtask

    initial begin
        rst_n = 0;
        if_pc = 32'h100;
        upd_valid = 0;
        upd_pc = 0;
        upd_taken = 0;
        upd_target = 0;
        upd_pred_taken = 0;
        upd_pred_target = 0;
        stat_clr = 0;
        checking = 1;
        #2;
        checkPred("reset 0x100", 0, 32'h0);
        checkOutput("reset branches", stat_branches, 32'h0);
        checkOutput("reset mispred", stat_mispred, 32'h0);
        checkOutput("reset mispredict", {31'h0, mispredict}, 32'h0);
        checkOutput("reset redirect", redirect_pc, 32'h0);
        #10 rst_n = 1;

        // First taken branch allocates and flushes to its target.
        applyStimulus(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0, 0);
        checkOutput("alloc mispredict", {31'h0, mispredict}, 32'h1);
        checkOutput("alloc redirect", redirect_pc, 32'h80);
        checkPred("alloc same cycle", 0, 32'h0);
        lookup(32'h100);
        checkPred("alloc next cycle", 1, 32'h80);

        // Hysteresis and saturation.
        applyStimulus(32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80, 0);
        checkOutput("nt redirect", redirect_pc, 32'h104);
        lookup(32'h100);
        checkPred("weak nt", 0, 32'h0);
        applyStimulus(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0, 0);
        applyStimulus(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
        applyStimulus(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80, 0);
        applyStimulus(32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80, 0);
        lookup(32'h100);
        checkPred("strong after one nt", 1, 32'h80);
        applyStimulus(32'h100, 1, 32'h100, 0, 32'h0, 1, 32'h80, 0);
        lookup(32'h100);
        checkPred("weak after two nt", 0, 32'h0);

        // Not-taken miss leaves the table alone; wrong target flushes.
        applyStimulus(32'h200, 1, 32'h200, 0, 32'h0, 0, 32'h0, 0);
        checkOutput("nt miss mispredict", {31'h0, mispredict}, 32'h0);
        checkOutput("nt miss redirect", redirect_pc, 32'h0);
        lookup(32'h200);
        checkPred("nt miss lookup", 0, 32'h0);
        applyStimulus(32'h200, 1, 32'h200, 1, 32'h300, 1, 32'h2F0, 0);
        checkOutput("target mispredict", {31'h0, mispredict}, 32'h1);
        checkOutput("target redirect", redirect_pc, 32'h300);

        // Aliasing on index 0 and read-during-write.
        applyStimulus(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h0, 0);
        lookup(32'h100);
        checkPred("retrain 0x100", 1, 32'h80);
        applyStimulus(32'h100, 1, 32'h200, 1, 32'h340, 0, 32'h0, 0);
        lookup(32'h100);
        checkPred("replaced 0x100", 0, 32'h0);
        applyStimulus(32'h200, 1, 32'h200, 0, 32'h0, 1, 32'h340, 0);
        checkPred("rdw old", 1, 32'h340);
        lookup(32'h200);
        checkPred("rdw new", 0, 32'h0);

        // Statistics.
        applyStimulus(32'h104, 1, 32'h200, 1, 32'h340, 0, 32'h0, 1);
        lookup(32'h104);
        checkOutput("clr branches", stat_branches, 32'h0);
        checkOutput("clr mispred", stat_mispred, 32'h0);
        applyStimulus(32'h104, 1, 32'h104, 1, 32'h500, 0, 32'h0, 0);
        applyStimulus(32'h104, 1, 32'h104, 1, 32'h500, 1, 32'h500, 0);
        applyStimulus(32'h104, 1, 32'h104, 1, 32'h500, 1, 32'h500, 0);
        applyStimulus(32'h104, 1, 32'h108, 0, 32'h0, 0, 32'h0, 0);
        applyStimulus(32'h104, 1, 32'h104, 0, 32'h0, 1, 32'h500, 0);
        lookup(32'h104);
        checkOutput("five branches", stat_branches, 32'd5);
        checkOutput("two mispred", stat_mispred, 32'd2);
        checkPred("0x104 after burst", 1, 32'h500);

        dut.branch_cnt = 32'hFFFF_FFFE;
        dut.mispred_cnt = 32'hFFFF_FFFF;
        mBranches = 64'hFFFF_FFFE;
        mMispred = 64'hFFFF_FFFF;
        applyStimulus(32'h104, 1, 32'h300, 1, 32'h40, 0, 32'h0, 0);
        applyStimulus(32'h104, 1, 32'h300, 1, 32'h44, 1, 32'h40, 0);
        lookup(32'h104);
        checkOutput("sat branches", stat_branches, 32'hFFFF_FFFF);
        checkOutput("sat mispred", stat_mispred, 32'hFFFF_FFFF);

        // Reset in the middle of an update burst.
        applyStimulus(32'h104, 1, 32'h400, 1, 32'h10, 0, 32'h0, 0);
        rst_n = 0;
        #1;
        checkOutput("midreset branches", stat_branches, 32'h0);
        checkOutput("midreset mispred", stat_mispred, 32'h0);
        checkPred("midreset 0x104", 0, 32'h0);
        checkOutput("midreset mispredict", {31'h0, mispredict}, 32'h0);
        checkOutput("midreset redirect", redirect_pc, 32'h0);
        @(negedge clk);
        #1;
        upd_valid = 0;
        rst_n = 1;
        lookup(32'h400);
        checkPred("dropped update", 0, 32'h0);
        checkOutput("post reset branches", stat_branches, 32'h0);

        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
